div16_seq: RTL

DIV16_SEQ -- requirements
Module: div16_seq

---
 rtl/div16_seq_pkg.sv | 13 +
 rtl/adder.sv | 41 ++++
 rtl/div16_seq.sv | 115 +++++++++++
 3 files changed

// File: rtl/div16_seq_pkg.sv
// rtl/div16_seq_pkg.sv - shared types and constants for the sequential divider
package div16_seq_pkg;

    localparam int DIV_W    = 16;
    localparam int ITER_CNT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/adder.sv
// rtl/adder.sv - 16-bit Kogge-Stone prefix adder with carry-in and carry-out
module adder (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        cin,
    output logic        cout,
    output logic [15:0] sum
);

    logic [15:0] prop;
    logic [15:0] carry_gen;

    assign prop = x ^ y;

    // Carry-in is folded into bit 0's generate so carry_gen[i] is the carry out of bit i.
    always_comb begin : prefix_tree
        logic [15:0] gg;
        logic [15:0] pp;
        logic [15:0] gn;
        logic [15:0] pn;
        gg    = (x & y) | {15'b0, prop[0] & cin};
        pp    = prop;
        gn    = gg;
        pn    = pp;
        for (int l = 0; l < 4; l++) begin
            gn = gg;
            pn = pp;
            for (int i = (1 << l); i < 16; i++) begin
                gn[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
                pn[i] = pp[i] & pp[i - (1 << l)];
            end
            gg = gn;
            pp = pn;
        end
        carry_gen = gg;
    end

    assign sum  = prop ^ {carry_gen[14:0], cin};
    assign cout = carry_gen[15];

endmodule

// File: rtl/div16_seq.sv
// rtl/div16_seq.sv - unsigned 16-bit restoring divider, one quotient bit per cycle
module div16_seq
    import div16_seq_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    state_t            state;
    state_t            state_next;
    logic [15:0]       cnt;
    logic [WIDTH-1:0]  quo_r;
    logic [WIDTH-1:0]  rem_r;
    logic [WIDTH-1:0]  dsr_r;
    logic              dz_r;
    logic [WIDTH:0]    shifted;
    logic [WIDTH-1:0]  diff;
    logic              carry;
    logic              take;
    logic              last_iter;

    // quo_r doubles as the dividend shift register; quotient bits enter at the LSB.
    assign shifted   = {rem_r, quo_r[WIDTH-1]};
    assign take      = shifted[WIDTH] | carry;
    assign last_iter = (cnt == 16'(ITER_CNT - 1));

    adder u_adder (
        .x    (shifted[WIDTH-1:0]),
        .y    (~dsr_r),
        .cin  (1'b1),
        .cout (carry),
        .sum  (diff)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (divisor == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            quo_r <= '0;
            rem_r <= '0;
            dsr_r <= '0;
            dz_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt   <= '0;
                        dsr_r <= divisor;
                        dz_r  <= (divisor == '0);
                        if (divisor == '0) begin
                            quo_r <= '1;
                            rem_r <= dividend;
                        end else begin
                            quo_r <= dividend;
                            rem_r <= '0;
                        end
                    end
                end
                RUN: begin
                    cnt   <= cnt + 16'd1;
                    quo_r <= {quo_r[WIDTH-2:0], take};
                    rem_r <= take ? diff : shifted[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

    assign quotient    = quo_r;
    assign remainder   = rem_r;
    assign div_by_zero = dz_r;

endmodule
